// File: rtl/radar_pkg.sv
// Shared radar constants: FSM encodings and default servo/PWM timing,
// reused by the sweep controller, the PWM stage and the ranging stage.
package radar_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MOVE = 2'd1,
      S_MEAS = 2'd2,
      S_STEP = 2'd3
   } state_e;

   localparam int RADAR_MIN_US    = 1000;
   localparam int RADAR_MAX_US    = 2000;
   localparam int RADAR_STEP_US   = 100;
   localparam int RADAR_PERIOD_US = 20000;

   function automatic int n_pos(input int min_us,
                                input int max_us,
                                input int step_us);
      return (max_us - min_us) / step_us + 1;
   endfunction

   localparam int RADAR_N_POS =
      n_pos(RADAR_MIN_US, RADAR_MAX_US, RADAR_STEP_US);

endpackage

// File: rtl/servo_sweep_us_tick.sv
// Free-running microsecond prescaler: one-cycle pulse every
// TICKS_PER_US clocks, phase set only by reset.
module us_tick #(
   parameter int TICKS_PER_US = 100
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_US - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/servo_sweep.sv
// Back-and-forth servo sweep: settle, measure via start/done handshake,
// publish one tagged sample per position and feed the PWM stage.
module servo_sweep
   import radar_pkg::*;
#(
   parameter int TICKS_PER_US    = 100,
   parameter int MIN_US          = RADAR_MIN_US,
   parameter int MAX_US          = RADAR_MAX_US,
   parameter int STEP_US         = RADAR_STEP_US,
   parameter int PERIOD_US       = RADAR_PERIOD_US,
   parameter int SETTLE_US       = 40000,
   parameter int MEAS_TIMEOUT_US = 30000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        meas_done,
   output logic        meas_start,
   output logic        pwm_enable,
   output logic [15:0] dutty,
   output logic [15:0] period,
   output logic [4:0]  position,
   output logic        sample_valid,
   output logic        sample_timeout,
   output logic        busy
);

   localparam int N_POS = n_pos(MIN_US, MAX_US, STEP_US);
   localparam int TMAX  = (SETTLE_US > MEAS_TIMEOUT_US) ?
                          SETTLE_US : MEAS_TIMEOUT_US;
   localparam int TW    = $clog2(TMAX + 1);

   localparam logic [TW-1:0] SETTLE_T = TW'(SETTLE_US);
   localparam logic [TW-1:0] TOUT_T   = TW'(MEAS_TIMEOUT_US);
   localparam logic [4:0]    LAST_POS = 5'(N_POS - 1);

   logic tick;

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [4:0]    pos_q, pos_d;
   logic          up_q, up_d;
   logic [15:0]   dutty_q, dutty_d;
   logic          en_q, en_d;
   logic          start_q, start_d;
   logic          sv_q, sv_d;
   logic          to_q, to_d;
   logic          busy_q, busy_d;

   us_tick #(
      .TICKS_PER_US(TICKS_PER_US)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (run) state_d = S_MOVE;
         S_MOVE: begin
            if (!run)                   state_d = S_IDLE;
            else if (timer_q == SETTLE_T) state_d = S_MEAS;
         end
         S_MEAS: begin
            if (!run)                   state_d = S_IDLE;
            else if (meas_done)         state_d = S_STEP;
            else if (timer_q == TOUT_T) state_d = S_STEP;
         end
         S_STEP: state_d = run ? S_MOVE : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q)
         timer_d = '0;
      else if (tick && (state_q == S_MOVE || state_q == S_MEAS))
         timer_d = timer_q + TW'(1);
   end

   // Direction flips as soon as an endpoint is reached, so it is
   // already correct for the next step.
   always_comb begin
      pos_d = pos_q;
      up_d  = up_q;
      if (state_q == S_STEP && N_POS > 1) begin
         pos_d = up_q ? pos_q + 5'd1 : pos_q - 5'd1;
         if (pos_d == LAST_POS)  up_d = 1'b0;
         else if (pos_d == 5'd0) up_d = 1'b1;
      end
   end

   always_comb begin
      dutty_d = dutty_q;
      if (state_d == S_MOVE && state_q != S_MOVE)
         dutty_d = 16'(MIN_US) + 16'(STEP_US) * {11'd0, pos_d};
      en_d    = (state_d != S_IDLE);
      busy_d  = (state_d != S_IDLE);
      start_d = (state_d == S_MEAS) && (state_q != S_MEAS);
      sv_d    = (state_d == S_STEP);
      to_d    = (state_d == S_STEP) && !meas_done;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         pos_q   <= '0;
         up_q    <= 1'b1;
         dutty_q <= 16'(MIN_US);
         en_q    <= 1'b0;
         start_q <= 1'b0;
         sv_q    <= 1'b0;
         to_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pos_q   <= pos_d;
         up_q    <= up_d;
         dutty_q <= dutty_d;
         en_q    <= en_d;
         start_q <= start_d;
         sv_q    <= sv_d;
         to_q    <= to_d;
         busy_q  <= busy_d;
      end
   end

   assign meas_start     = start_q;
   assign pwm_enable     = en_q;
   assign dutty          = dutty_q;
   assign period         = 16'(PERIOD_US);
   assign position       = pos_q;
   assign sample_valid   = sv_q;
   assign sample_timeout = to_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_servo_sweep.sv
// Directed bench for servo_sweep: sweep order, timeout, done/timeout
// tie, run drop and asynchronous reset mid-measurement.
module tb_servo_sweep;

   logic        clk = 1'b0;
   logic        reset, run, meas_done;
   logic        meas_start, pwm_enable, sample_valid, sample_timeout, busy;
   logic [15:0] dutty, period;
   logic [4:0]  position;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int pos;
      int dutty;
      int tout;
   } vec_t;

   vec_t tbl[8];

   servo_sweep #(
      .TICKS_PER_US   (2),
      .MIN_US         (1000),
      .MAX_US         (1300),
      .STEP_US        (100),
      .PERIOD_US      (20000),
      .SETTLE_US      (5),
      .MEAS_TIMEOUT_US(8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .meas_done     (meas_done),
      .meas_start    (meas_start),
      .pwm_enable    (pwm_enable),
      .dutty         (dutty),
      .period        (period),
      .position      (position),
      .sample_valid  (sample_valid),
      .sample_timeout(sample_timeout),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Edge count since reset release; the prescaler phase follows it.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic wait_start(output int e0);
      int k;
      k = 0;
      while (!meas_start && k < 200) begin
         step();
         k++;
      end
      chk("meas_start_seen", int'(meas_start), 1);
      e0 = cyc;
   endtask

   // dly > 0: done sampled dly edges after meas_start; 0: never;
   // -2: done sampled on the very edge the timeout would fire.
   task automatic finish_sample(input int dly, input int e0,
                                output int p, output int d,
                                output int t, output int lat);
      int k;
      int dd;
      k  = 0;
      dd = dly;
      if (dly == -2) dd = (e0 % 2 == 0) ? 17 : 16;
      while (!sample_valid && k < 100) begin
         if (dd > 0 && cyc == e0 + dd - 1) meas_done = 1'b1;
         step();
         meas_done = 1'b0;
         k++;
      end
      chk("sample_seen", int'(sample_valid), 1);
      p   = int'(position);
      d   = int'(dutty);
      t   = int'(sample_timeout);
      lat = cyc - e0;
   endtask

   initial begin
      int e0, p, d, t, lat, cnt;

      tbl[0] = '{0, 1000, 0};
      tbl[1] = '{1, 1100, 0};
      tbl[2] = '{2, 1200, 0};
      tbl[3] = '{3, 1300, 0};
      tbl[4] = '{2, 1200, 0};
      tbl[5] = '{1, 1100, 0};
      tbl[6] = '{0, 1000, 0};
      tbl[7] = '{1, 1100, 0};

      reset     = 1'b1;
      run       = 1'b0;
      meas_done = 1'b0;
      repeat (3) step();
      chk("rst_pwm_enable", int'(pwm_enable), 0);
      chk("rst_dutty", int'(dutty), 1000);
      chk("rst_period", int'(period), 20000);
      chk("rst_busy", int'(busy), 0);
      chk("rst_position", int'(position), 0);
      reset = 1'b0;

      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (pwm_enable || busy || meas_start || sample_valid) cnt++;
      end
      chk("idle_activity", cnt, 0);
      chk("idle_dutty", int'(dutty), 1000);
      chk("idle_period", int'(period), 20000);

      run = 1'b1;
      step();
      chk("run_pwm_enable", int'(pwm_enable), 1);
      chk("run_busy", int'(busy), 1);

      for (int i = 0; i < 8; i++) begin
         wait_start(e0);
         if (i == 0) begin
            step();
            chk("meas_start_1cyc", int'(meas_start), 0);
         end
         finish_sample(3, e0, p, d, t, lat);
         chk($sformatf("seq%0d_pos", i), p, tbl[i].pos);
         chk($sformatf("seq%0d_dutty", i), d, tbl[i].dutty);
         chk($sformatf("seq%0d_tout", i), t, tbl[i].tout);
         if (i == 0) chk("done_latency", lat, 3);
      end

      wait_start(e0);
      finish_sample(0, e0, p, d, t, lat);
      chk("tout_pos", p, 2);
      chk("tout_flag", t, 1);
      chk("tout_lat_16_18", int'(lat >= 16 && lat <= 18), 1);
      step();
      chk("tout_next_pos", int'(position), 3);
      chk("tout_next_dutty", int'(dutty), 1300);
      chk("tout_sv_1cyc", int'(sample_valid), 0);

      wait_start(e0);
      finish_sample(-2, e0, p, d, t, lat);
      chk("tie_pos", p, 3);
      chk("tie_flag", t, 0);
      chk("tie_latency", lat, (e0 % 2 == 0) ? 17 : 16);
      step();
      chk("tie_single_sample", int'(sample_valid), 0);
      chk("tie_next_pos", int'(position), 2);

      repeat (2) step();
      run = 1'b0;
      step();
      chk("drop_pwm_enable", int'(pwm_enable), 0);
      chk("drop_busy", int'(busy), 0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (sample_valid || meas_start || busy) cnt++;
      end
      chk("drop_no_sample", cnt, 0);
      chk("drop_pos_held", int'(position), 2);
      run = 1'b1;
      wait_start(e0);
      finish_sample(3, e0, p, d, t, lat);
      chk("resume_pos", p, 2);
      chk("resume_dutty", d, 1200);

      for (int i = 0; i < 4; i++) begin
         wait_start(e0);
         finish_sample(3, e0, p, d, t, lat);
         chk($sformatf("down%0d_pos", i), p, (i == 0) ? 1 :
                                             (i == 1) ? 0 :
                                             (i == 2) ? 1 : 2);
      end

      wait_start(e0);
      chk("pre_rst_pos", int'(position), 3);
      step();
      step();
      #2 reset = 1'b1;
      #1;
      chk("arst_pwm_enable", int'(pwm_enable), 0);
      chk("arst_dutty", int'(dutty), 1000);
      chk("arst_position", int'(position), 0);
      cnt = int'(busy) + int'(meas_start) + int'(sample_valid) +
            int'(sample_timeout);
      chk("arst_flags", cnt, 0);
      step();
      #2 reset = 1'b0;
      #1;
      chk("arst_still_idle", int'(busy), 0);
      wait_start(e0);
      finish_sample(3, e0, p, d, t, lat);
      chk("post_rst_pos0", p, 0);
      wait_start(e0);
      finish_sample(3, e0, p, d, t, lat);
      chk("post_rst_pos1", p, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
